// File: rtl/gpu_pkg.sv
// Shared GPU pixel-path definitions: widths, sys port constants and reader FSM states.
package gpu_pkg;

    localparam int PIXEL_W    = 24;
    localparam int ADDR_W     = 32;
    localparam int POS_W      = 16;
    localparam int LEN_W      = 24;
    localparam int SYS_DATA_W = PIXEL_W;
    localparam int SYS_ADDR_W = ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        STREAM,
        DRAIN,
        DONE
    } rd_state_t;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
module gpu_pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_pixel_reader.sv
// Fetches a linear run of pixels from the SDRAM sys read port and streams them
// to a consumer through a credit-limited FWFT FIFO.
module gpu_pixel_reader
    import gpu_pkg::*;
#(
    parameter int H_DISP     = 0,
    parameter int V_DISP     = 0,
    parameter int LOAD_WAIT  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [POS_W-1:0]      xpos,
    input  logic [POS_W-1:0]      ypos,
    input  logic [LEN_W-1:0]      len,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [PIXEL_W-1:0]    pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    input  logic                  sysVaild,
    input  logic [SYS_DATA_W-1:0] sysReadData,
    output logic                  sysLoad,
    output logic                  sysReadEnable,
    output logic [SYS_ADDR_W-1:0] sysAddrMin,
    output logic [SYS_ADDR_W-1:0] sysAddrMax
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_t          state;
    logic [LEN_W-1:0]   run_len;
    logic [LEN_W-1:0]   issued;
    logic [LEN_W-1:0]   delivered;
    logic [15:0]        wait_cnt;
    logic               inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [PIXEL_W-1:0] fifo_head;
    logic [CNT_W:0]     credit_used;
    logic               pop;

    // Consumer handshake: a pixel transfers on any cycle with pix_valid & pix_ready;
    // pix_data is the FIFO head and holds while pix_valid & !pix_ready.
    assign pix_valid = (fifo_count != '0);
    assign pix_data  = pix_valid ? fifo_head : '0;
    assign pop       = pix_valid && pix_ready;

    // The word in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_used   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign sysReadEnable = (state == STREAM) && sysVaild && (issued < run_len)
                           && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

    gpu_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (sysReadData),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sysLoad    <= 1'b0;
            sysAddrMin <= '0;
            sysAddrMax <= '0;
            run_len    <= '0;
            issued     <= '0;
            delivered  <= '0;
            wait_cnt   <= '0;
            inflight   <= 1'b0;
        end else begin
            sysLoad  <= 1'b0;
            inflight <= sysReadEnable;
            if (sysReadEnable) begin
                issued <= issued + 1'b1;
            end
            if (pop) begin
                delivered <= delivered + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        run_len   <= len;
                        issued    <= '0;
                        delivered <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            busy       <= 1'b1;
                            sysLoad    <= 1'b1;
                            sysAddrMin <= ADDR_W'(xpos) + ADDR_W'(ypos) * ADDR_W'(H_DISP);
                            sysAddrMax <= ADDR_W'(H_DISP) * ADDR_W'(V_DISP + 1);
                        end
                    end
                end
                LOAD: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == 16'(LOAD_WAIT - 1)) begin
                        state <= STREAM;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (issued == run_len) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (delivered == run_len) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_pixel_reader.sv
// Directed bench for gpu_pixel_reader with a behavioural SDRAM read-port model.
module tb_gpu_pixel_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] xpos, ypos;
    logic [23:0] len;
    logic        start;
    logic        busy, done;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        sysVaild = 1'b1;
    logic [23:0] sysReadData = '0;
    logic        sysLoad, sysReadEnable;
    logic [31:0] sysAddrMin, sysAddrMax;

    int tests = 0;
    int fails = 0;

    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          load_cnt, re_cnt, viol_cnt;
    logic [31:0] cur_addr = '0;
    logic        toggle_mode = 1'b0;

    gpu_pixel_reader #(
        .H_DISP(800), .V_DISP(480), .LOAD_WAIT(4), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .len(len), .start(start),
        .busy(busy), .done(done), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .sysVaild(sysVaild), .sysReadData(sysReadData),
        .sysLoad(sysLoad), .sysReadEnable(sysReadEnable),
        .sysAddrMin(sysAddrMin), .sysAddrMax(sysAddrMax)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input logic [31:0] a);
        return {a[7:0] ^ 8'h5A, a[15:0]};
    endfunction

    // SDRAM controller read port: word appears the cycle after each pop.
    always @(posedge clk) begin
        if (sysLoad) cur_addr <= sysAddrMin;
        else if (sysReadEnable) cur_addr <= cur_addr + 1;
        if (sysReadEnable) sysReadData <= pat(cur_addr);
        sysVaild <= toggle_mode ? ~sysVaild : 1'b1;
    end

    always @(negedge clk) begin
        if (sysLoad) load_cnt++;
        if (sysReadEnable) begin
            re_cnt++;
            if (!sysVaild) viol_cnt++;
        end
        if (pix_valid && pix_ready) got_q.push_back(pix_data);
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        load_cnt = 0; re_cnt = 0; viol_cnt = 0;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic fill_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pat(base + 32'(i)));
    endtask

    task automatic start_run(input logic [15:0] x, input logic [15:0] y, input logic [23:0] l);
        xpos = x; ypos = y; len = l; start = 1'b1;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int k = 0;
        while (!done && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: done=%0b after %0d cycles, required 1", name, done, k);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({busy, done, sysLoad, sysReadEnable, pix_valid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: busy/done/load/re/valid=%b, required 00000",
                     {busy, done, sysLoad, sysReadEnable, pix_valid});
        end
        tests++;
        if (pix_data !== 24'h0) begin
            fails++; $display("FAIL reset_pix_data: got %h, required 000000", pix_data);
        end
        tests++;
        if (sysAddrMin !== 32'd0 || sysAddrMax !== 32'd0) begin
            fails++; $display("FAIL reset_addr: min=%0d max=%0d, required 0 0", sysAddrMin, sysAddrMax);
        end
    endtask

    task automatic test_basic();
        int lat = 0;
        logic [31:0] amin = '0, amax = '0;
        clear_mon(); fill_exp(32'd1610, 16);
        start_run(16'd10, 16'd2, 24'd16);
        while (!pix_valid && lat < 40) begin
            @(negedge clk); lat++;
            if (sysLoad) begin amin = sysAddrMin; amax = sysAddrMax; end
        end
        tests++;
        if (amin !== 32'd1610) begin fails++; $display("FAIL basic_addr_min: got %0d, required 1610", amin); end
        tests++;
        if (amax !== 32'd384800) begin fails++; $display("FAIL basic_addr_max: got %0d, required 384800", amax); end
        tests++;
        if (!pix_valid || lat < 7) begin
            fails++; $display("FAIL basic_latency: first valid after %0d cycles (valid=%0b), required >=7", lat, pix_valid);
        end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %0b, required 1", busy); end
        wait_done(200, "basic");
        tests++;
        if (load_cnt != 1 || re_cnt != 16) begin
            fails++; $display("FAIL basic_sys_counts: loads=%0d reads=%0d, required 1 16", load_cnt, re_cnt);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done: got %0b, required 0", busy); end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL basic_count: got %0d pixels, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL basic_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        start = 1'b0; tick(1);
    endtask

    task automatic test_zero_len();
        int busy_seen = 0;
        clear_mon();
        start_run(16'd3, 16'd3, 24'd0);
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL zero_done: done=%0b busy=%0b, required 1 0", done, busy);
        end
        repeat (5) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        tests++;
        if (busy_seen != 0 || load_cnt != 0 || re_cnt != 0) begin
            fails++; $display("FAIL zero_quiet: busy_cycles=%0d loads=%0d reads=%0d, required 0 0 0",
                              busy_seen, load_cnt, re_cnt);
        end
        start = 1'b0; @(negedge clk);
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL zero_release: done=%0b, required 0", done); end
    endtask

    task automatic test_backpressure();
        logic [23:0] held;
        clear_mon(); fill_exp(32'd80000, 40);
        pix_ready = 1'b0;
        start_run(16'd0, 16'd100, 24'd40);
        tick(20);
        held = pix_data;
        tick(30);
        tests++;
        if (re_cnt != 8) begin fails++; $display("FAIL bp_outstanding: reads=%0d, required 8", re_cnt); end
        tests++;
        if (pix_valid !== 1'b1 || pix_data !== held || pix_data !== exp_q[0]) begin
            fails++; $display("FAIL bp_hold: valid=%0b data=%h earlier=%h, required 1 %h",
                              pix_valid, pix_data, held, exp_q[0]);
        end
        pix_ready = 1'b1;
        wait_done(400, "bp");
        tests++;
        if (got_q.size() != exp_q.size() || re_cnt != 40) begin
            fails++; $display("FAIL bp_count: pixels=%0d reads=%0d, required 40 40", got_q.size(), re_cnt);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL bp_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        start = 1'b0; tick(1);
    endtask

    task automatic test_vaild_toggle();
        clear_mon(); fill_exp(32'd5, 12);
        toggle_mode = 1'b1;
        start_run(16'd5, 16'd0, 24'd12);
        wait_done(400, "toggle");
        tests++;
        if (viol_cnt != 0 || re_cnt != 12) begin
            fails++; $display("FAIL toggle_reads: reads_without_vaild=%0d reads=%0d, required 0 12", viol_cnt, re_cnt);
        end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL toggle_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL toggle_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        start = 1'b0; toggle_mode = 1'b0; tick(2);
    endtask

    task automatic test_reset_mid();
        int k = 0, ld, re;
        clear_mon(); fill_exp(32'd1600, 20);
        start_run(16'd0, 16'd2, 24'd20);
        while (got_q.size() < 5 && k < 200) begin
            @(negedge clk); #1; k++;
        end
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, sysLoad, sysReadEnable, pix_valid} !== 5'b0 || pix_data !== 24'h0
            || sysAddrMin !== 32'd0 || sysAddrMax !== 32'd0) begin
            fails++; $display("FAIL rstmid_outputs: ctrl=%b data=%h min=%0d max=%0d, required 00000 0 0 0",
                              {busy, done, sysLoad, sysReadEnable, pix_valid}, pix_data, sysAddrMin, sysAddrMax);
        end
        tests++;
        if (got_q.size() != 5 || got_q[0] !== exp_q[0] || got_q[4] !== exp_q[4]) begin
            fails++; $display("FAIL rstmid_prefix: got %0d pixels, required first 5 in order", got_q.size());
        end
        rst = 1'b0;
        ld = load_cnt; re = re_cnt;
        tick(10);
        tests++;
        if (load_cnt != ld || re_cnt != re) begin
            fails++; $display("FAIL rstmid_quiet: loads=%0d reads=%0d, required %0d %0d", load_cnt, re_cnt, ld, re);
        end
        clear_mon(); fill_exp(32'd0, 6);
        start_run(16'd0, 16'd0, 24'd6);
        wait_done(200, "rstmid_rerun");
        tests++;
        if (got_q.size() != 6 || re_cnt != 6) begin
            fails++; $display("FAIL rstmid_rerun_count: pixels=%0d reads=%0d, required 6 6", got_q.size(), re_cnt);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL rstmid_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        start = 1'b0; tick(1);
    endtask

    task automatic test_start_held();
        clear_mon(); fill_exp(32'd8007, 4);
        start_run(16'd7, 16'd10, 24'd4);
        wait_done(200, "held_first");
        tick(20);
        tests++;
        if (load_cnt != 1 || re_cnt != 4 || done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL held_single_run: loads=%0d reads=%0d done=%0b busy=%0b, required 1 4 1 0",
                              load_cnt, re_cnt, done, busy);
        end
        start = 1'b0; @(negedge clk);
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL held_release: done=%0b, required 0", done); end
        clear_mon(); fill_exp(32'd8007, 4);
        start_run(16'd7, 16'd10, 24'd4);
        wait_done(200, "held_second");
        tests++;
        if (load_cnt != 1 || got_q.size() != 4) begin
            fails++; $display("FAIL held_second_run: loads=%0d pixels=%0d, required 1 4", load_cnt, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL held_pix[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        start = 1'b0; tick(1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
        xpos = '0; ypos = '0; len = '0;
        tick(3);
        test_reset();
        rst = 1'b0;
        tick(1);
        test_basic();
        test_zero_len();
        test_backpressure();
        test_vaild_toggle();
        test_reset_mid();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
